// File: rtl/accum_ctrl_if.sv
// rtl/accum_ctrl_if.sv - request/status bundle between board inputs and accum_ctrl
interface accum_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int LED_W = 8
);
    logic             enable;
    logic [WIDTH-1:0] value;
    logic             sub;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic [LED_W-1:0] led;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output enable, value, sub, clear,
        input  count, led, busy, done, ovf
    );

    modport slave (
        input  enable, value, sub, clear,
        output count, led, busy, done, ovf
    );
endinterface

// File: rtl/accum_ctrl.sv
// rtl/accum_ctrl.sv - enable-triggered delayed accumulator with LED slice, saturation and sticky overflow
module accum_ctrl #(
    parameter int WIDTH       = 32,
    parameter int LED_W       = 8,
    parameter int LED_LSB     = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int SATURATE    = 0
) (
    input  logic         CLK,
    input  logic         RST,
    accum_ctrl_if.slave  bus
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             sub_q, sub_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    logic             accept;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic             flow;
    logic [WIDTH-1:0] result;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            count_q <= '0;
            op_q    <= '0;
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            sub_q   <= sub_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (bus.enable) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACC;
                S_WAIT: if (wcnt_q == '0) state_d = S_ACC;
                S_ACC:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // WIDTH+1 bit arithmetic exposes add carry and subtract borrow in the top bit
    always_comb begin
        sum_w  = {1'b0, count_q} + {1'b0, op_q};
        diff_w = {1'b0, count_q} - {1'b0, op_q};
        flow   = sub_q ? diff_w[WIDTH] : sum_w[WIDTH];
        result = sub_q ? diff_w[WIDTH-1:0] : sum_w[WIDTH-1:0];
        if ((SATURATE != 0) && flow) begin
            result = sub_q ? '0 : '1;
        end
    end

    always_comb begin
        accept  = (state_q == S_IDLE) && bus.enable && !bus.clear;
        op_d    = op_q;
        sub_d   = sub_q;
        wcnt_d  = wcnt_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (accept) begin
            op_d   = bus.value;
            sub_d  = bus.sub;
            wcnt_d = WAIT_LOAD;
        end
        if (state_q == S_WAIT && wcnt_q != '0) begin
            wcnt_d = wcnt_q - 1'b1;
        end
        if (bus.clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (state_q == S_ACC) begin
            count_d = result;
            ovf_d   = ovf_q | flow;
            done_d  = 1'b1;
        end
    end

    always_comb begin
        bus.count = count_q;
        bus.led   = count_q[LED_LSB +: LED_W];
        bus.busy  = (state_q != S_IDLE);
        bus.done  = done_q;
        bus.ovf   = ovf_q;
    end
endmodule

// File: tb/tb_accum_ctrl.sv
// tb/tb_accum_ctrl.sv - four accum_ctrl variants on shared stimulus against an operation-schedule model
module tb_accum_ctrl;
    localparam int N = 4;
    localparam int WC [0:N-1] = '{1, 1, 0, 4};
    localparam int SA [0:N-1] = '{0, 1, 0, 0};

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic        sub;
    logic        clear;
    logic [31:0] value;

    always #5 CLK = ~CLK;

    logic [31:0] d_count [N];
    logic [7:0]  d_led   [N];
    logic        d_busy  [N];
    logic        d_done  [N];
    logic        d_ovf   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        accum_ctrl_if #(.WIDTH(32), .LED_W(8)) bus ();
        assign bus.enable = enable;
        assign bus.value  = value;
        assign bus.sub    = sub;
        assign bus.clear  = clear;
        accum_ctrl #(
            .WIDTH(32), .LED_W(8), .LED_LSB(16),
            .WAIT_CYCLES(WC[g]), .SATURATE(SA[g])
        ) dut (
            .CLK(CLK),
            .RST(RST),
            .bus(bus)
        );
        assign d_count[g] = bus.count;
        assign d_led[g]   = bus.led;
        assign d_busy[g]  = bus.busy;
        assign d_done[g]  = bus.done;
        assign d_ovf[g]   = bus.ovf;
    end

    // Model: each accepted op is scheduled to land WAIT_CYCLES+1 edges after its accepting edge
    logic [31:0] m_count [N];
    logic [31:0] m_op    [N];
    bit          m_sub   [N];
    bit          m_ovf   [N];
    bit          m_done  [N];
    bit          m_pend  [N];
    int          m_due   [N];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt0 = 0;

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic apply_op(input int i);
        longint s;
        if (m_sub[i]) begin
            if (m_op[i] > m_count[i]) begin
                m_ovf[i]   = 1'b1;
                m_count[i] = (SA[i] != 0) ? 32'h0 : m_count[i] - m_op[i];
            end else begin
                m_count[i] = m_count[i] - m_op[i];
            end
        end else begin
            s = longint'(m_count[i]) + longint'(m_op[i]);
            if (s > 64'hFFFF_FFFF) begin
                m_ovf[i]   = 1'b1;
                m_count[i] = (SA[i] != 0) ? 32'hFFFF_FFFF : 32'(s);
            end else begin
                m_count[i] = 32'(s);
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (RST) begin
                m_count[i] = '0; m_op[i] = '0; m_sub[i] = 0;
                m_ovf[i] = 0; m_done[i] = 0; m_pend[i] = 0;
            end else if (clear) begin
                m_count[i] = '0; m_ovf[i] = 0; m_done[i] = 0; m_pend[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_pend[i] && cyc == m_due[i]) begin
                    apply_op(i);
                    m_done[i] = 1;
                    m_pend[i] = 0;
                end else if (!m_pend[i] && enable) begin
                    m_pend[i] = 1;
                    m_due[i]  = cyc + WC[i] + 1;
                    m_op[i]   = value;
                    m_sub[i]  = sub;
                end
            end
        end
        #1;
        if (d_done[0] === 1'b1) done_cnt0++;
        for (int i = 0; i < N; i++) begin
            chk("count", i, d_count[i], m_count[i]);
            chk("led", i, 32'(d_led[i]), (m_count[i] >> 16) & 32'hFF);
            chk("busy", i, 32'(d_busy[i]), 32'(m_pend[i]));
            chk("done", i, 32'(d_done[i]), 32'(m_done[i]));
            chk("ovf", i, 32'(d_ovf[i]), 32'(m_ovf[i]));
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; enable = 0; clear = 0; sub = 0; value = '0;
        step();
        RST = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] v, input logic s);
        enable = 1'b1; value = v; sub = s;
        step();
        enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            value = $urandom; sub = 1'($urandom);
            step();
        end
    endtask

    initial begin
        RST = 1'b1; enable = 0; clear = 0; sub = 0; value = '0;
        step();
        step();
        chk("rst_count", 0, d_count[0], 32'h0);
        chk("rst_busy", 0, 32'(d_busy[0]), 32'h0);
        RST = 1'b0;

        do_op(32'h0001_0000, 1'b0);
        chk("t1_count", 0, d_count[0], 32'h0001_0000);
        chk("t1_led", 0, 32'(d_led[0]), 32'h01);

        do_reset();
        done_cnt0 = 0;
        enable = 1'b1; value = 32'h0010_0000; sub = 0;
        for (int k = 0; k < 12; k++) step();
        chk("held_done_pulses", 0, 32'(done_cnt0), 32'd4);
        chk("held_count", 0, d_count[0], 32'h0040_0000);
        chk("held_led", 0, 32'(d_led[0]), 32'h40);
        enable = 1'b0;
        for (int k = 0; k < 6; k++) step();

        do_reset();
        do_op(32'hFFFF_FFF0, 1'b0);
        do_op(32'h0000_0020, 1'b0);
        chk("wrap_add", 0, d_count[0], 32'h0000_0010);
        chk("sat_add", 1, d_count[1], 32'hFFFF_FFFF);
        chk("ovf_set", 0, 32'(d_ovf[0]), 32'h1);
        do_op(32'h1, 1'b0);
        chk("ovf_sticky", 0, 32'(d_ovf[0]), 32'h1);

        do_reset();
        do_op(32'd5, 1'b0);
        do_op(32'd8, 1'b1);
        chk("wrap_sub", 0, d_count[0], 32'hFFFF_FFFD);
        chk("sat_sub", 1, d_count[1], 32'h0);
        chk("sub_ovf", 1, 32'(d_ovf[1]), 32'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_ovf", 0, 32'(d_ovf[0]), 32'h0);

        do_reset();
        do_op(32'd1, 1'b0);
        chk("w0_one", 2, d_count[2], 32'h1);
        chk("w4_one", 3, d_count[3], 32'h1);

        enable = 1'b1; value = 32'd7; step();
        clear = 1'b1; step();
        clear = 1'b0; enable = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("clear_abort", 3, d_count[3], 32'h0);

        enable = 1'b1; value = 32'd9; step();
        RST = 1'b1; step();
        RST = 1'b0; enable = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("rst_abort", 0, d_count[0], 32'h0);

        clear = 1'b1; enable = 1'b1; value = 32'd3; step();
        clear = 1'b0; enable = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("clear_beats_en", 0, d_count[0], 32'h0);

        for (int k = 0; k < 600; k++) begin
            enable = 1'($urandom);
            sub    = 1'($urandom);
            value  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0003_0000);
            clear  = ($urandom_range(0, 29) == 0);
            RST    = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
